// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch-stage control, IF/ID and instruction-memory signal bundle
interface if_fetch_stage_if;
    logic        PCWrite;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] inst;
    logic [15:0] PC_Plus2;
    logic        inst_valid;
    logic        flush;

    modport master (
        input  PCWrite, branch_taken, branch_target, jump, jump_target,
        input  imem_rdata, imem_ready,
        output imem_req, imem_addr, inst, PC_Plus2, inst_valid, flush
    );

    modport slave (
        output PCWrite, branch_taken, branch_target, jump, jump_target,
        output imem_rdata, imem_ready,
        input  imem_req, imem_addr, inst, PC_Plus2, inst_valid, flush
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, imem handshake with wait states,
// stall hold buffer and branch/jump redirect with stale-response discard
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_stage_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_inst_buf;
    logic [15:0] r_discard_addr;

    logic        w_redirect;
    logic [15:0] w_target_raw;
    logic [15:0] w_target;
    logic [15:0] w_pc_plus2;
    logic        w_valid;
    logic [15:0] w_data;

    // Branch beats jump: the branch belongs to the older instruction.
    always_comb begin
        w_redirect   = bus.branch_taken | bus.jump;
        w_target_raw = bus.branch_taken ? bus.branch_target : bus.jump_target;
        w_target     = {w_target_raw[15:1], 1'b0};
        w_pc_plus2   = r_pc + 16'd2;
    end

    always_comb begin
        w_valid = 1'b0;
        w_data  = bus.imem_rdata;
        case (r_state)
            FETCH:   w_valid = bus.imem_ready & ~w_redirect;
            HOLD: begin
                w_valid = ~w_redirect;
                w_data  = r_inst_buf;
            end
            default: w_valid = 1'b0;
        endcase
    end

    // A stale response still owns the bus in DISCARD, so its address must not move.
    always_comb begin
        bus.imem_req   = (r_state == FETCH) || (r_state == DISCARD);
        bus.imem_addr  = (r_state == DISCARD) ? r_discard_addr : r_pc;
        bus.inst_valid = w_valid;
        bus.inst       = w_valid ? w_data : NOP_INST;
        bus.PC_Plus2   = w_pc_plus2;
        bus.flush      = w_redirect & reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_pc           <= RESET_PC;
            r_inst_buf     <= 16'h0000;
            r_discard_addr <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_redirect) r_pc <= w_target;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (!bus.imem_ready) begin
                            r_discard_addr <= r_pc;
                            r_state        <= DISCARD;
                        end
                    end else if (bus.imem_ready) begin
                        if (bus.PCWrite) begin
                            r_pc <= w_pc_plus2;
                        end else begin
                            r_inst_buf <= bus.imem_rdata;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= FETCH;
                    end else if (bus.PCWrite) begin
                        r_pc    <= w_pc_plus2;
                        r_state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (w_redirect) r_pc <= w_target;
                    if (bus.imem_ready) r_state <= FETCH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and runs the instruction-memory request handshake, tolerating wait states.
- Applies stall (PCWrite) and redirect (branch/jump) with branch priority.
- Presents inst, PC_Plus2 and a flush pulse that the IF/ID register consumes.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_INST, 16'h0000: instruction driven on inst when inst_valid=0 (bubble).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCWrite  in  1  1 = downstream accepts the current instruction and PC advances; 0 = stall.
- branch_taken  in  1  branch resolved taken this cycle.
- branch_target  in  16  branch destination.
- jump  in  1  jump decoded this cycle.
- jump_target  in  16  jump destination.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  16  request address.
- imem_rdata  in  16  read data, valid when imem_ready=1.
- imem_ready  in  1  request completes this cycle; may be same cycle as imem_req.
- inst  out  16  fetched instruction to IF/ID.
- PC_Plus2  out  16  address of inst + 2, to IF/ID.
- inst_valid  out  1  inst/PC_Plus2 hold a real instruction.
- flush  out  1  redirect taken; drives IF/ID flush.

Behaviour:
- States: IDLE, FETCH, HOLD, DISCARD. Registers: pc, state, inst_buf, discard_addr.
- Reset (async, reset=0): state=IDLE, pc=RESET_PC, inst_buf=0, discard_addr=0. Outputs while in reset: imem_req=0, inst_valid=0, inst=NOP_INST, flush=0, PC_Plus2=RESET_PC+2.
- Reset asserted mid-access abandons the access. No response after reset is consumed unless it belongs to a new request.
- redirect = branch_taken | jump.
- redirect target = branch_target if branch_taken, else jump_target. Branch wins when both are set, because it is the older instruction. Target bit0 is forced to 0.
- flush = redirect, combinational, in every state except during reset.
- PC_Plus2 = pc+2, modulo 2^16 (16'hFFFE+2 = 16'h0000).
- IDLE:
  - imem_req=0, inst_valid=0.
  - Next state is FETCH.
  - A redirect loads pc with the target.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - redirect & imem_ready: pc<=target, stay in FETCH, inst_valid=0 (squash).
  - redirect & !imem_ready: discard_addr<=pc, pc<=target, go to DISCARD, inst_valid=0.
  - !redirect & imem_ready & PCWrite: inst=imem_rdata, inst_valid=1, pc<=pc+2, stay in FETCH. Zero-wait memory gives 1 instruction/cycle.
  - !redirect & imem_ready & !PCWrite: inst=imem_rdata, inst_valid=1, inst_buf<=imem_rdata, go to HOLD.
  - !imem_ready: inst_valid=0, inst=NOP_INST, hold pc.
- HOLD:
  - imem_req=0, inst=inst_buf, inst_valid=1.
  - redirect: pc<=target, go to FETCH, inst_valid=0.
  - else if PCWrite: pc<=pc+2, go to FETCH.
  - else stay in HOLD, with pc and inst stable.
- DISCARD:
  - imem_req=1, imem_addr=discard_addr. Address stays stable while the request is outstanding.
  - inst_valid=0.
  - imem_ready: data is dropped, go to FETCH.
  - A redirect in DISCARD updates pc to the new target. The last redirect wins.
- Handshake rule: imem_addr never changes while imem_req=1 and imem_ready=0.
- PCWrite is ignored whenever inst_valid=0.

Test Plan:
- Zero-wait fetch: reset release, imem_ready tied 1, PCWrite=1, rdata=addr^16'hA5A5 -> IDLE for 1 cycle, then imem_addr 0,2,4,6 on consecutive cycles. inst_valid=1 each cycle, with inst=16'hA5A5,16'hA5A7,... and PC_Plus2=2,4,6,8.
- Wait states plus stall: memory takes 3 cycles, PCWrite=0 for 4 cycles after data returns at pc=16'h0010 -> inst_valid low for 2 cycles, then HOLD. inst stays stable and imem_req=0 during the stall. After PCWrite=1, the next imem_addr is 16'h0012.
- Redirect during outstanding access: request at 16'h0020 not ready, jump=1 with jump_target=16'h0100 -> flush=1 for 1 cycle. imem_addr holds 16'h0020 until ready, and that data is dropped (inst_valid=0). The next request goes to 16'h0100.
- Simultaneous branch and jump: branch_target=16'h0200, jump_target=16'h0300, both asserted in FETCH with ready -> next imem_addr=16'h0200, flush=1, inst_valid=0 that cycle.
- Wrap and odd target: pc=16'hFFFE with PCWrite=1 -> PC_Plus2=16'h0000, and the next address is 16'h0000. Then branch_target=16'h0041 -> next imem_addr=16'h0040.
- Mid-operation reset: assert reset while in DISCARD -> imem_req=0 and inst_valid=0 immediately. After release, IDLE for 1 cycle, then imem_addr=RESET_PC.
